// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-timing derivation,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Integer truncation is intentional: 1 MHz / 9600 gives 104.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like an edge after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start edge, samples each bit
// at its centre and reports a good byte (rx_valid) or a low stop bit (frame_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rx_s;
    logic             rx_prev;
    logic             fall;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Previous synchronized sample; resets high so a low line at release
    // is only seen as a start once it has been high first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_prev <= 1'b1;
        else        rx_prev <= rx_s;
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) state_d = RX_START;
            end

            // Mid-start check rejects glitches shorter than half a bit.
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A break holds the line low; stay busy until it returns high.
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = RX_IDLE;
            end

            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial driver feeds frames, a reference
// model queues the expected bytes/errors, and a monitor compares DUT pulses.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 9600;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int LAT_NOM   = 2 + CPB / 2 + 9 * CPB + 1;
    localparam int LAT_MIN   = LAT_NOM - 2;
    localparam int LAT_MAX   = LAT_NOM + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    int         exp_t_q[$];
    logic [7:0] err_q[$];
    int         err_t_q[$];
    logic [7:0] model_last = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    // Clock and reset
    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Driver tasks
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_t_q.push_back(cyc);
            model_last = b;
        end else begin
            err_q.push_back(model_last);
            err_t_q.push_back(cyc);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx = stop_ok;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // Monitor / scoreboard
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err) check("pulse_exclusive", {rx_valid, frame_err} == 2'b11, 0);
            if (rx_valid && prev_valid) check("valid_one_cycle", 1, 0);
            if (frame_err && prev_err) check("err_one_cycle", 1, 0);
            if (rx_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", rx_data, 32'hffff_ffff);
                end else begin
                    logic [7:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("rx_data", rx_data, e);
                    check_range("valid_latency", cyc - t, LAT_MIN, LAT_MAX);
                end
            end
            if (frame_err && !prev_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frame_err", 1, 0);
                end else begin
                    logic [7:0] e;
                    int t;
                    e = err_q.pop_front();
                    t = err_t_q.pop_front();
                    check("err_data_held", rx_data, e);
                    check_range("err_latency", cyc - t, LAT_MIN, LAT_MAX);
                end
            end
        end
        prev_valid = rx_valid;
        prev_err   = frame_err;
    end

    initial begin
        int t0;
        int n;
        logic [7:0] b;
        logic bad;
        int gap;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", rx_busy, 0);

        // Single byte, then back-to-back pair
        send_byte(8'h41, 1'b1);
        repeat (50) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);

        // Start glitch of 20 cycles
        rx = 1'b0;
        t0 = cyc;
        repeat (5) @(negedge clk);
        check("glitch_busy_rise", rx_busy, 1);
        repeat (15) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (rx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_range("glitch_busy_fall", cyc - t0, 1, CPB / 2 + 3);
        repeat (20) @(negedge clk);

        // Bad stop followed by a long break
        send_byte(8'h33, 1'b0);
        n = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!rx_busy) n++;
        end
        check("break_busy_low_cycles", n, 0);
        rx = 1'b1;
        n = 0;
        while (rx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("break_busy_released", rx_busy, 0);
        repeat (10) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (30) @(negedge clk);

        // Reset during bit 4
        @(negedge clk);
        b = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        model_last = 8'h00;
        #1;
        check("abort_rx_busy", rx_busy, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_frame_err", frame_err, 0);
        check("abort_rx_data", rx_data, 8'h00);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", rx_busy, 0);
        send_byte(8'hC3, 1'b1);
        repeat (20) @(negedge clk);

        // Randomized frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 12; k++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
            send_byte(b, !bad);
            if (bad) begin
                rx = 1'b1;
                gap = gap + 20;
            end
            repeat (gap) @(negedge clk);
        end
        rx = 1'b1;

        // Drain and final report
        n = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("pending_bytes", exp_q.size(), 0);
        check("pending_errors", err_q.size(), 0);
        check("final_rx_data", rx_data, model_last);
        check("final_idle", rx_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
